valid_strobe_gen: RTL and testbench
===================================

// Module: valid_strobe_gen
// PURPOSE
//  Produces the o_valid strobe that advances the LED flash/shift registers downstream.
//  Counts clock cycles up to a limit picked by the board switches, then emits a one-cycle pulse.
//  i_enable low gates the strobe off; i_step then issues single manual pulses (edge detected).
//  Sits between the switch/button inputs and every LED register that has a valid input.
// PARAMETERS
//  NB_COUNTER  32       width of the cycle counter
//  NB_PULSES   8        width of the issued-pulse counter o_pulses
//  R0          2**14    limit for i_rate=2'b00 (fastest)
//  R1          2**16    limit for i_rate=2'b01
//  R2          2**18    limit for i_rate=2'b10
//  R3          2**20    limit for i_rate=2'b11 (slowest); all limits >=2 and < 2**NB_COUNTER
// PORTS
//  clock      in   1          system clock, all logic on posedge
//  i_reset    in   1          asynchronous reset, ACTIVE-LOW
//  i_enable   in   1          1 = free-running strobe; 0 = halted/manual mode
//  i_rate     in   2          selects the limit from R0..R3
//  i_step     in   1          manual step request (level input, rising edge acts)
//  o_valid    out  1          one-cycle strobe to the downstream LED registers
//  o_pulses   out  NB_PULSES  count of issued strobes, wraps modulo 2**NB_PULSES
//  o_running  out  1          1 while the FSM is in RUN
// BEHAVIOUR
//  Reset (i_reset=0, asynchronous): state=IDLE, counter=0, o_valid=0, o_pulses=0, o_running=0,
//   step_d=0, rate_d=i_rate sampled at the first clock edge after release. Mid-operation reset aborts the count.
//  FSM: IDLE -> RUN when i_enable=1. RUN -> IDLE when i_enable=0; counter cleared the same edge.
//  RUN: counter increments every cycle; when counter==limit-1, o_valid=1 for exactly one cycle
//   and counter->0. Period = limit cycles; first pulse occurs limit cycles after entering RUN.
//  Rate change: rate_d is a registered copy of i_rate. If i_rate!=rate_d in RUN, counter->0,
//   no pulse that cycle, and the new limit applies from 0. A partial count never emits a pulse.
//  IDLE: step_d is the registered i_step. If i_step=1 and step_d=0, o_valid=1 on the next edge
//   (1 cycle latency). Holding i_step high gives exactly one pulse.
//  i_step is ignored in RUN. A step edge on the same cycle as i_enable rising is dropped.
//   RUN takes priority.
//  o_valid is registered, never high on two consecutive cycles unless limit... (limit>=2 forbids it).
//  o_pulses increments on every o_valid=1 cycle. It wraps from 2**NB_PULSES-1 to 0 without a flag.
//  o_running is registered and equals (state==RUN).
//  Counter compare uses NB_COUNTER-bit unsigned arithmetic. Limits are truncated to NB_COUNTER bits.
//  i_enable, i_rate and i_step are synchronous to clock. No synchronizers are inside this block.
// TESTING
//  Bench overrides R0=4, R1=6, R2=8, R3=10, NB_PULSES=3.
//  T1 reset: i_reset=0 with i_enable=1 -> o_valid=0, o_pulses=0, o_running=0.
//     Release -> o_running=1 after 1 edge.
//  T2 rate 00, enable held: pulses every 4 cycles. First pulse 4 cycles after RUN entry.
//     After 9 pulses, o_pulses=1 (wrap-around checked).
//  T3 switch i_rate 00->11 two cycles into a period -> no pulse.
//     Next pulse exactly 10 cycles after the change.
//  T4 i_enable=0, i_step held high 5 cycles -> exactly one o_valid, 1 cycle after the rising edge.
//     Second rising edge -> second pulse. o_pulses=2.
//  T5 i_enable dropped at counter=2 (R0), then raised -> counter restarts.
//     No pulse for 4 cycles after re-entry.
//  T6 async reset asserted mid-period between clock edges -> outputs 0 immediately.
//     After release, full-period first pulse and o_pulses=0.

Source files
------------

// File: rtl/valid_strobe_gen.sv
// valid_strobe_gen: one-cycle strobe generator for the LED register chain.
// In RUN the strobe repeats every "limit" cycles, the limit being picked by
// i_rate. In IDLE each rising edge of i_step issues one manual strobe.
// o_pulses counts every issued strobe and wraps silently.
module valid_strobe_gen #(
  parameter int unsigned NB_COUNTER = 32,
  parameter int unsigned NB_PULSES  = 8,
  parameter int unsigned R0         = 2**14,
  parameter int unsigned R1         = 2**16,
  parameter int unsigned R2         = 2**18,
  parameter int unsigned R3         = 2**20
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [1:0]           i_rate,
  input  logic                 i_step,
  output logic                 o_valid,
  output logic [NB_PULSES-1:0] o_pulses,
  output logic                 o_running
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Terminal counts (limit - 1), limits truncated to the counter width.
  localparam logic [NB_COUNTER-1:0] ONE     = NB_COUNTER'(1);
  localparam logic [NB_COUNTER-1:0] LIM0_M1 = NB_COUNTER'(R0) - ONE;
  localparam logic [NB_COUNTER-1:0] LIM1_M1 = NB_COUNTER'(R1) - ONE;
  localparam logic [NB_COUNTER-1:0] LIM2_M1 = NB_COUNTER'(R2) - ONE;
  localparam logic [NB_COUNTER-1:0] LIM3_M1 = NB_COUNTER'(R3) - ONE;

  state_t                  state_q, state_d;
  logic [NB_COUNTER-1:0]   cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic [NB_PULSES-1:0]    pulses_q, pulses_d;
  logic                    running_q;
  logic                    step_q;
  logic [1:0]              rate_q;
  logic [NB_COUNTER-1:0]   limit_m1;

  // Terminal count for the currently registered rate selection.
  always_comb begin
    limit_m1 = LIM0_M1;
    case (rate_q)
      2'b00:   limit_m1 = LIM0_M1;
      2'b01:   limit_m1 = LIM1_M1;
      2'b10:   limit_m1 = LIM2_M1;
      default: limit_m1 = LIM3_M1;
    endcase
  end

  // Next state, counter and strobe decision; entering RUN wins over a step edge,
  // and a rate change restarts the count so a partial period never strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_enable) begin
          state_d = RUN;
        end else if (i_step && !step_q) begin
          valid_d = 1'b1;
        end
      end
      RUN: begin
        if (!i_enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (i_rate != rate_q) begin
          cnt_d = '0;
        end else if (cnt_q == limit_m1) begin
          cnt_d   = '0;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase
    pulses_d = pulses_q + NB_PULSES'(valid_d);
  end

  // State and output registers; reset aborts any count in progress.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      pulses_q  <= '0;
      running_q <= 1'b0;
      step_q    <= 1'b0;
      rate_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      pulses_q  <= pulses_d;
      running_q <= (state_d == RUN);
      step_q    <= i_step;
      rate_q    <= i_rate;
    end
  end

  assign o_valid   = valid_q;
  assign o_pulses  = pulses_q;
  assign o_running = running_q;

endmodule

// File: tb/tb_valid_strobe_gen.sv
// Bench for valid_strobe_gen: directed scenarios plus random stimulus, every
// cycle compared against a period/phase reference model.
module tb_valid_strobe_gen;

  localparam int NBP = 3;

  logic           clock = 1'b0;
  logic           i_reset;
  logic           i_enable;
  logic [1:0]     i_rate;
  logic           i_step;
  logic           o_valid;
  logic [NBP-1:0] o_pulses;
  logic           o_running;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: running flag, edge index at which the current
  // period phase started, last sampled step/rate, expected strobe and count.
  bit         m_running;
  bit         m_valid;
  bit         m_step_prev;
  logic [1:0] m_rate_prev;
  int         m_pulses;
  int         m_anchor;
  int         edge_k;

  always #5 clock = ~clock;

  valid_strobe_gen #(
    .NB_COUNTER(32),
    .NB_PULSES (NBP),
    .R0        (4),
    .R1        (6),
    .R2        (8),
    .R3        (10)
  ) dut (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_rate   (i_rate),
    .i_step   (i_step),
    .o_valid  (o_valid),
    .o_pulses (o_pulses),
    .o_running(o_running)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rate_limit(input logic [1:0] r);
    return 4 + 2 * int'(r);
  endfunction

  task automatic model_reset();
    m_running   = 1'b0;
    m_valid     = 1'b0;
    m_step_prev = 1'b0;
    m_rate_prev = 2'b00;
    m_pulses    = 0;
  endtask

  // One clock edge of the reference: a strobe is due whenever a whole number
  // of periods has elapsed since the phase anchor.
  task automatic model_edge();
    bit was_run;
    was_run = m_running;
    m_valid = 1'b0;
    edge_k++;
    if (!i_reset) begin
      model_reset();
      return;
    end
    if (!was_run) begin
      if (i_enable) begin
        m_running = 1'b1;
        m_anchor  = edge_k;
      end else if (i_step && !m_step_prev) begin
        m_valid = 1'b1;
      end
    end else if (!i_enable) begin
      m_running = 1'b0;
    end else if (i_rate != m_rate_prev) begin
      m_anchor = edge_k;
    end else if (((edge_k - m_anchor) % rate_limit(i_rate)) == 0) begin
      m_valid = 1'b1;
    end
    m_step_prev = i_step;
    m_rate_prev = i_rate;
    m_pulses   += int'(m_valid);
  endtask

  // Advance one clock, update the model, then compare all outputs.
  task automatic tick(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_eq({tag, ".valid"},   32'(o_valid),   32'(m_valid));
    check_eq({tag, ".running"}, 32'(o_running), 32'(m_running));
    check_eq({tag, ".pulses"},  32'(o_pulses),  32'(m_pulses % (1 << NBP)));
    if (o_valid === 1'b1)
      $display("strobe %s t=%0t o_pulses=%0d", tag, $time, o_pulses);
  endtask

  initial begin
    int np;
    int first;
    logic [NBP-1:0] p0;
    logic [NBP-1:0] pdiff;

    i_reset  = 1'b0;
    i_enable = 1'b1;
    i_rate   = 2'b00;
    i_step   = 1'b0;
    edge_k   = 0;
    m_anchor = 0;
    model_reset();

    // T1: held in reset with enable high, then release.
    tick("t1_rst");
    tick("t1_rst");
    check_eq("t1_rst_valid",   32'(o_valid),   32'd0);
    check_eq("t1_rst_pulses",  32'(o_pulses),  32'd0);
    check_eq("t1_rst_running", 32'(o_running), 32'd0);
    @(negedge clock);
    i_reset = 1'b1;
    tick("t1");
    check_eq("t1_running", 32'(o_running), 32'd1);

    // T2: rate 00, nine periods of four cycles, counter wraps to 1.
    np    = 0;
    first = -1;
    for (int i = 1; i <= 36; i++) begin
      tick("t2");
      if (o_valid === 1'b1) begin
        np++;
        if (first < 0) first = i;
      end
    end
    check_eq("t2_first", 32'(first), 32'd4);
    check_eq("t2_count", 32'(np), 32'd9);
    check_eq("t2_wrap",  32'(o_pulses), 32'd1);

    // T3: rate 00 -> 11 two cycles into a period.
    tick("t3");
    tick("t3");
    i_rate = 2'b11;
    first  = -1;
    for (int i = 0; i < 30; i++) begin
      tick("t3");
      if (o_valid === 1'b1 && first < 0) first = i;
    end
    check_eq("t3_next", 32'(first), 32'd10);

    // T4: manual mode, held step gives one strobe, second edge another.
    i_enable = 1'b0;
    tick("t4");
    p0     = o_pulses;
    i_step = 1'b1;
    np     = 0;
    first  = -1;
    for (int i = 0; i < 5; i++) begin
      tick("t4");
      if (o_valid === 1'b1) begin
        np++;
        if (first < 0) first = i;
      end
    end
    check_eq("t4_one",     32'(np), 32'd1);
    check_eq("t4_latency", 32'(first), 32'd0);
    i_step = 1'b0;
    tick("t4");
    i_step = 1'b1;
    tick("t4");
    check_eq("t4_second", 32'(o_valid), 32'd1);
    pdiff = o_pulses - p0;
    check_eq("t4_pulses", 32'(pdiff), 32'd2);
    i_step = 1'b0;

    // T5: enable dropped at counter 2, raised again: fresh full period.
    i_rate   = 2'b00;
    i_enable = 1'b1;
    tick("t5");
    tick("t5");
    tick("t5");
    i_enable = 1'b0;
    tick("t5");
    i_enable = 1'b1;
    tick("t5");
    np = 0;
    for (int i = 0; i < 3; i++) begin
      tick("t5");
      if (o_valid === 1'b1) np++;
    end
    check_eq("t5_quiet", 32'(np), 32'd0);
    tick("t5");
    check_eq("t5_pulse", 32'(o_valid), 32'd1);

    // T6: asynchronous reset between edges, mid-period.
    tick("t6");
    tick("t6");
    #2;
    i_reset = 1'b0;
    #1;
    check_eq("t6_async_valid",   32'(o_valid),   32'd0);
    check_eq("t6_async_pulses",  32'(o_pulses),  32'd0);
    check_eq("t6_async_running", 32'(o_running), 32'd0);
    model_reset();
    @(negedge clock);
    i_reset = 1'b1;
    tick("t6");
    check_eq("t6_pulses0", 32'(o_pulses), 32'd0);
    for (int i = 0; i < 3; i++) tick("t6");
    tick("t6");
    check_eq("t6_first", 32'(o_valid), 32'd1);

    // Random: enable toggles, rate switches and step activity.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) i_enable = ~i_enable;
      if ($urandom_range(0, 19) == 0) i_rate = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) i_step = ~i_step;
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
